diff_commit_stage: RTL and testbench

Registered staging stage between the core's two commit ports and the difftest bridge. It captures the per-slot commit records plus their load/store events and the exception event each cycle. It compacts the two slots so a lone commit always appears on output slot 0, and assigns difftest slot indices. It also maintains a retired-instruction counter and a no-commit watchdog that flags a hung core.

---
 rtl/diff_pkg.sv | 50 +++++
 rtl/diff_watchdog.sv | 44 ++++
 rtl/diff_commit_stage.sv | 133 +++++++++++++
 tb/tb_diff_commit_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// Shared record types, slot index constants and output gating helpers
// for the difftest commit staging stage.
package diff_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        csrRstat;
    logic [63:0] csrData;
  } commit_rec_t;

  typedef struct packed {
    logic [7:0]  valid;
    logic [63:0] paddr;
    logic [63:0] vaddr;
    logic [63:0] data;
    logic [7:0]  len;
  } mem_ev_t;

  localparam logic [7:0] SLOT0_IDX = 8'd0;
  localparam logic [7:0] SLOT1_IDX = 8'd1;

  // An empty output slot carries nothing; writes to x0 are never architectural.
  function automatic commit_rec_t gate_rec(input commit_rec_t rec, input logic vld);
    commit_rec_t r;
    r     = rec;
    r.wen = rec.wen & (rec.wdest != 8'd0);
    if (!vld) begin
      r = '0;
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic mem_ev_t gate_ev(input mem_ev_t ev, input logic vld);
    mem_ev_t e;
    if (vld) begin
      e = ev;
    end else begin
      e = '0;
    end
    return e;
  endfunction

endpackage

// File: rtl/diff_watchdog.sv
// No-commit watchdog: saturating idle counter with a sticky timeout flag
// that only reset clears.
module diff_watchdog
#(
  parameter int TIMEOUT = 5000,
  parameter int CNT_W   = 32
)
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_timeout;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_active) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == TIMEOUT_C) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= r_timeout | (w_cnt_nxt == TIMEOUT_C);
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/diff_commit_stage.sv
// Registered staging of two commit slots toward the difftest bridge:
// compaction, index assignment, gating, instret and hang watchdog.
module diff_commit_stage
  import diff_pkg::*;
#(
  parameter int TIMEOUT = 5000,
  parameter int CNT_W   = 32
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            in_valid,
  input  commit_rec_t [1:0]     in_rec,
  input  mem_ev_t [1:0]         in_store,
  input  mem_ev_t [1:0]         in_load,
  input  logic                  in_excp_valid,
  input  logic                  in_is_mret,
  input  logic [31:0]           in_intrpt_no,
  input  logic [31:0]           in_cause,
  input  logic [63:0]           in_excp_pc,
  input  logic [31:0]           in_excp_inst,
  output logic [1:0]            out_valid,
  output logic [1:0][7:0]       out_index,
  output commit_rec_t [1:0]     out_rec,
  output mem_ev_t [1:0]         out_store,
  output mem_ev_t [1:0]         out_load,
  output logic                  out_excp_valid,
  output logic                  out_excp_is_mret,
  output logic [31:0]           out_excp_intrpt_no,
  output logic [31:0]           out_excp_cause,
  output logic [63:0]           out_excp_pc,
  output logic [31:0]           out_excp_inst,
  output logic [63:0]           instret,
  output logic                  timeout
);

  logic [1:0]        w_valid;
  logic              w_src0;
  logic [1:0]        w_pop;
  commit_rec_t [1:0] w_rec;
  mem_ev_t [1:0]     w_store;
  mem_ev_t [1:0]     w_load;

  logic [1:0]        r_valid;
  logic [1:0][7:0]   r_index;
  commit_rec_t [1:0] r_rec;
  mem_ev_t [1:0]     r_store;
  mem_ev_t [1:0]     r_load;
  logic              r_excp_valid;
  logic              r_excp_is_mret;
  logic [31:0]       r_excp_intrpt_no;
  logic [31:0]       r_excp_cause;
  logic [63:0]       r_excp_pc;
  logic [31:0]       r_excp_inst;
  logic [63:0]       r_instret;

  // Output slot 1 can only ever be fed by input slot 1; slot 0 takes whichever is oldest.
  always_comb begin
    w_valid = 2'b00;
    w_src0  = 1'b0;
    case (in_valid)
      2'b01:   begin w_valid = 2'b01; w_src0 = 1'b0; end
      2'b10:   begin w_valid = 2'b01; w_src0 = 1'b1; end
      2'b11:   begin w_valid = 2'b11; w_src0 = 1'b0; end
      default: begin w_valid = 2'b00; w_src0 = 1'b0; end
    endcase
  end

  always_comb begin
    w_rec[0]   = gate_rec(w_src0 ? in_rec[1]   : in_rec[0],   w_valid[0]);
    w_store[0] = gate_ev (w_src0 ? in_store[1] : in_store[0], w_valid[0]);
    w_load[0]  = gate_ev (w_src0 ? in_load[1]  : in_load[0],  w_valid[0]);
    w_rec[1]   = gate_rec(in_rec[1],   w_valid[1]);
    w_store[1] = gate_ev (in_store[1], w_valid[1]);
    w_load[1]  = gate_ev (in_load[1],  w_valid[1]);
    w_pop      = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid          <= 2'b00;
      r_index          <= '0;
      r_rec            <= '0;
      r_store          <= '0;
      r_load           <= '0;
      r_excp_valid     <= 1'b0;
      r_excp_is_mret   <= 1'b0;
      r_excp_intrpt_no <= 32'd0;
      r_excp_cause     <= 32'd0;
      r_excp_pc        <= 64'd0;
      r_excp_inst      <= 32'd0;
      r_instret        <= 64'd0;
    end else begin
      r_valid          <= w_valid;
      r_index[0]       <= SLOT0_IDX;
      r_index[1]       <= w_valid[1] ? SLOT1_IDX : 8'd0;
      r_rec            <= w_rec;
      r_store          <= w_store;
      r_load           <= w_load;
      r_excp_valid     <= in_excp_valid;
      r_excp_is_mret   <= in_excp_valid & in_is_mret;
      r_excp_intrpt_no <= in_intrpt_no;
      r_excp_cause     <= in_cause;
      r_excp_pc        <= in_excp_pc;
      r_excp_inst      <= in_excp_inst;
      r_instret        <= r_instret + {62'd0, w_pop};
    end
  end

  diff_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_active  ((|in_valid) | in_excp_valid),
    .o_timeout (timeout)
  );

  assign out_valid          = r_valid;
  assign out_index          = r_index;
  assign out_rec            = r_rec;
  assign out_store          = r_store;
  assign out_load           = r_load;
  assign out_excp_valid     = r_excp_valid;
  assign out_excp_is_mret   = r_excp_is_mret;
  assign out_excp_intrpt_no = r_excp_intrpt_no;
  assign out_excp_cause     = r_excp_cause;
  assign out_excp_pc        = r_excp_pc;
  assign out_excp_inst      = r_excp_inst;
  assign instret            = r_instret;

endmodule

// File: tb/tb_diff_commit_stage.sv
// Randomized self-checking bench for diff_commit_stage against a queue-based
// reference model of compaction, gating, instret and the idle watchdog.
module tb_diff_commit_stage;
  import diff_pkg::*;

  localparam int TO = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        in_valid;
  commit_rec_t [1:0] in_rec;
  mem_ev_t [1:0]     in_store;
  mem_ev_t [1:0]     in_load;
  logic              in_excp_valid;
  logic              in_is_mret;
  logic [31:0]       in_intrpt_no;
  logic [31:0]       in_cause;
  logic [63:0]       in_excp_pc;
  logic [31:0]       in_excp_inst;
  logic [1:0]        out_valid;
  logic [1:0][7:0]   out_index;
  commit_rec_t [1:0] out_rec;
  mem_ev_t [1:0]     out_store;
  mem_ev_t [1:0]     out_load;
  logic              out_excp_valid;
  logic              out_excp_is_mret;
  logic [31:0]       out_excp_intrpt_no;
  logic [31:0]       out_excp_cause;
  logic [63:0]       out_excp_pc;
  logic [31:0]       out_excp_inst;
  logic [63:0]       instret;
  logic              timeout;

  diff_commit_stage #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_rec(in_rec),
    .in_store(in_store), .in_load(in_load), .in_excp_valid(in_excp_valid),
    .in_is_mret(in_is_mret), .in_intrpt_no(in_intrpt_no), .in_cause(in_cause),
    .in_excp_pc(in_excp_pc), .in_excp_inst(in_excp_inst), .out_valid(out_valid),
    .out_index(out_index), .out_rec(out_rec), .out_store(out_store),
    .out_load(out_load), .out_excp_valid(out_excp_valid),
    .out_excp_is_mret(out_excp_is_mret), .out_excp_intrpt_no(out_excp_intrpt_no),
    .out_excp_cause(out_excp_cause), .out_excp_pc(out_excp_pc),
    .out_excp_inst(out_excp_inst), .instret(instret), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs and abstract model state
  logic [1:0]  e_valid;
  logic [7:0]  e_index [2];
  commit_rec_t e_rec [2];
  mem_ev_t     e_store [2];
  mem_ev_t     e_load [2];
  logic        e_xv, e_xm;
  logic [31:0] e_xno, e_xcause, e_xinst;
  logic [63:0] e_xpc;
  logic [63:0] m_instret;
  int          m_idle;
  logic        m_timeout;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic commit_rec_t rand_rec();
    commit_rec_t r;
    r.pc = r64(); r.instr = $urandom; r.skip = 1'($urandom); r.wen = 1'($urandom);
    r.wdest = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    r.wdata = r64(); r.csrRstat = 1'($urandom); r.csrData = r64();
    return r;
  endfunction

  function automatic mem_ev_t rand_ev();
    mem_ev_t e;
    e.valid = 8'($urandom); e.paddr = r64(); e.vaddr = r64(); e.data = r64(); e.len = 8'($urandom);
    return e;
  endfunction

  task automatic randomize_inputs();
    int p;
    p = $urandom_range(0, 9);
    in_valid = (p < 4) ? 2'b00 : 2'($urandom);
    for (int k = 0; k < 2; k++) begin
      in_rec[k] = rand_rec(); in_store[k] = rand_ev(); in_load[k] = rand_ev();
    end
    in_excp_valid = ($urandom_range(0, 9) == 0);
    in_is_mret = 1'($urandom); in_intrpt_no = $urandom; in_cause = $urandom;
    in_excp_pc = r64(); in_excp_inst = $urandom;
  endtask

  task automatic clear_inputs();
    in_valid = 2'b00; in_rec = '0; in_store = '0; in_load = '0;
    in_excp_valid = 1'b0; in_is_mret = 1'b0; in_intrpt_no = 32'd0; in_cause = 32'd0;
    in_excp_pc = 64'd0; in_excp_inst = 32'd0;
  endtask

  task automatic model_reset();
    e_valid = 2'b00;
    for (int j = 0; j < 2; j++) begin
      e_index[j] = 8'd0; e_rec[j] = '0; e_store[j] = '0; e_load[j] = '0;
    end
    e_xv = 1'b0; e_xm = 1'b0; e_xno = 32'd0; e_xcause = 32'd0; e_xpc = 64'd0; e_xinst = 32'd0;
    m_instret = 64'd0; m_idle = 0; m_timeout = 1'b0;
  endtask

  // Oldest valid commits fill output slots in order; the rest stay empty.
  task automatic model_edge();
    int src[$];
    src = {};
    for (int k = 0; k < 2; k++) if (in_valid[k]) src.push_back(k);
    for (int j = 0; j < 2; j++) begin
      if (j < src.size()) begin
        e_valid[j] = 1'b1; e_index[j] = 8'(j);
        e_rec[j] = in_rec[src[j]];
        e_rec[j].wen = in_rec[src[j]].wen && (in_rec[src[j]].wdest != 8'd0);
        e_store[j] = in_store[src[j]]; e_load[j] = in_load[src[j]];
      end else begin
        e_valid[j] = 1'b0; e_index[j] = 8'd0; e_rec[j] = '0; e_store[j] = '0; e_load[j] = '0;
      end
    end
    e_xv = in_excp_valid; e_xm = in_excp_valid && in_is_mret;
    e_xno = in_intrpt_no; e_xcause = in_cause; e_xpc = in_excp_pc; e_xinst = in_excp_inst;
    m_instret = m_instret + 64'(src.size());
    if (src.size() != 0 || in_excp_valid) m_idle = 0;
    else m_idle++;
    if (m_idle >= TO) m_timeout = 1'b1;
  endtask

  task automatic check_all();
    chk("out_valid", 256'(out_valid), 256'(e_valid));
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("index%0d", j), 256'(out_index[j]), 256'(e_index[j]));
      chk($sformatf("rec%0d", j),   256'(out_rec[j]),   256'(e_rec[j]));
      chk($sformatf("store%0d", j), 256'(out_store[j]), 256'(e_store[j]));
      chk($sformatf("load%0d", j),  256'(out_load[j]),  256'(e_load[j]));
    end
    chk("excp_valid", 256'(out_excp_valid), 256'(e_xv));
    chk("excp_mret",  256'(out_excp_is_mret), 256'(e_xm));
    chk("excp_no",    256'(out_excp_intrpt_no), 256'(e_xno));
    chk("excp_cause", 256'(out_excp_cause), 256'(e_xcause));
    chk("excp_pc",    256'(out_excp_pc), 256'(e_xpc));
    chk("excp_inst",  256'(out_excp_inst), 256'(e_xinst));
    chk("instret",    256'(instret), 256'(m_instret));
    chk("timeout",    256'(timeout), 256'(m_timeout));
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Dual commit
    clear_inputs();
    in_valid = 2'b11; in_rec[0].pc = 64'h8000_0000; in_rec[1].pc = 64'h8000_0004;
    step();
    chk("dual_instret", 256'(instret), 256'(64'd2));

    // Lone slot1 with a store
    clear_inputs();
    in_valid = 2'b10; in_rec[1].pc = 64'h8000_0010; in_store[1].valid = 8'h0F;
    in_store[0].valid = 8'hAA;
    step();
    chk("lone1_pc", 256'(out_rec[0].pc), 256'(64'h8000_0010));
    chk("lone1_st", 256'(out_store[0].valid), 256'(8'h0F));

    // x0 write, and store bytes on an invalid slot
    clear_inputs();
    in_valid = 2'b01; in_rec[0].wen = 1'b1; in_rec[0].wdest = 8'd0; in_rec[0].wdata = 64'hDEAD;
    in_store[1].valid = 8'hFF;
    step();
    chk("x0_wen", 256'(out_rec[0].wen), 256'(1'b0));
    chk("inv_store", 256'(out_store[1].valid), 256'(8'h00));

    // Exception together with a commit
    clear_inputs();
    in_valid = 2'b01; in_excp_valid = 1'b1; in_cause = 32'd11; in_excp_pc = 64'h8000_0020;
    in_is_mret = 1'b1;
    step();

    // mret without exception must not pass
    clear_inputs();
    in_is_mret = 1'b1; in_valid = 2'b01;
    step();

    // Watchdog from reset
    async_reset();
    clear_inputs();
    for (int i = 0; i < TO - 1; i++) step();
    chk("wd_pre", 256'(timeout), 256'(1'b0));
    step();
    chk("wd_set", 256'(timeout), 256'(1'b1));
    in_valid = 2'b11;
    step();
    chk("wd_sticky", 256'(timeout), 256'(1'b1));
    clear_inputs();
    async_reset();
    chk("wd_reset", 256'(timeout), 256'(1'b0));

    // Randomized traffic with occasional idle bursts and a mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      if (i % 97 == 50) begin
        clear_inputs();
        for (int k = 0; k < TO + 2; k++) step();
      end
      randomize_inputs();
      step();
    end

    // instret wrap
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    clear_inputs();
    in_valid = 2'b01;
    step();
    chk("wrap", 256'(instret), 256'(64'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
